lfsr_checker: RTL
=================

// Module: lfsr_checker
// PURPOSE
//  Receive-side companion of the team's LFSR pattern generator. Accepts a stream of words
//  from that generator, possibly through a DUT or link. Self-synchronises by seeding its
//  own LFSR from the stream, then predicts every following word and reports mismatches.
//  Keeps saturating word-error and bit-error counts. Used as the checker in ALU/datapath
//  loopback benches.
// PARAMETERS
//  BIT_WIDTH     4   word width; must be >= 2. Polynomial matches the generator (below).
//  SYNC_MATCHES  3   consecutive matching beats needed in SYNC before declaring lock.
//  LOSS_THRESH   4   consecutive mismatching beats in LOCKED that drop lock.
//  CNT_WIDTH     16  width of both error counters.
// PORTS
//  clk          in   1          clock; all state updates on posedge.
//  rstn         in   1          reset, synchronous, active-low.
//  valid_in     in   1          data_in carries a generator word this cycle.
//  data_in      in   BIT_WIDTH  received word.
//  clr_in       in   1          clears both error counters; lock state is unaffected.
//  locked_out   out  1          checker is in LOCKED.
//  err_out      out  1          one-cycle pulse: previous beat mismatched while LOCKED.
//  err_cnt_out  out  CNT_WIDTH  saturating count of mismatched words while LOCKED.
//  bit_err_cnt_out out CNT_WIDTH saturating count of mismatched bits while LOCKED.
// BEHAVIOUR
//  - Next-state function: nxt(s) = {s[1]^s[0], s[BIT_WIDTH-1:1]}.
//    For 4 bits this is {s1^s0, s3, s2, s1}.
//  - All outputs are registered. A response appears in the cycle after the valid_in beat.
//    Cycles without valid_in change nothing except clr_in handling.
//  - Reset (rstn=0 at posedge): state=HUNT; expected=0; sync_cnt=0; loss_cnt=0.
//    All outputs are 0. Reset has priority over every other input, including mid-lock.
//  - HUNT:
//    * Valid beat with data_in != 0: expected <= nxt(data_in); sync_cnt <= 0; go to SYNC.
//    * Valid beat with data_in == 0 is the lock-up word. Ignore it and stay in HUNT.
//  - SYNC:
//    * Valid beat with data_in == expected: expected <= nxt(expected); sync_cnt++.
//    * When the match makes sync_cnt reach SYNC_MATCHES, go to LOCKED.
//      loss_cnt <= 0; locked_out=1 from the next cycle.
//    * Mismatch with data_in != 0: reseed. expected <= nxt(data_in); sync_cnt <= 0.
//    * Mismatch with data_in == 0: go to HUNT.
//    * Errors are never counted in HUNT or SYNC.
//  - LOCKED:
//    * Every valid beat advances the LFSR from its own prediction: expected <= nxt(expected).
//      The LFSR is never reloaded from data_in in this state.
//    * Match: loss_cnt <= 0.
//    * Mismatch: err_out=1 for exactly one cycle; err_cnt += 1;
//      bit_err_cnt += popcount(data_in ^ expected); loss_cnt++.
//    * When loss_cnt reaches LOSS_THRESH, go to HUNT, locked_out=0, and clear sync_cnt.
//      The error of that beat is still counted.
//  - Counters saturate at 2^CNT_WIDTH-1 and never wrap. A bit-count add that would
//    overflow clamps to max.
//  - clr_in on a cycle with no error: both counters become 0.
//  - clr_in together with a counted error: counters become the new increment only
//    (err_cnt=1, bit_err_cnt=popcount).
//  - No backpressure. The checker accepts every valid beat.
// TESTING  (BIT_WIDTH=4, SYNC_MATCHES=3, LOSS_THRESH=4; stream 1001,1100,0110,1011,0101,1010)
//  1 Reset mid-lock:
//    rstn=0 for one cycle while LOCKED with err_cnt=5
//    -> locked_out=0, err_cnt=0, bit_err_cnt=0, err_out=0 on the next cycle.
//  2 Lock acquisition:
//    valid beats 1001,1100,0110,1011 back-to-back
//    -> locked_out=0 through the 3rd response, =1 the cycle after 1011; counters stay 0.
//  3 Single error:
//    locked, send 0100 instead of 0101, then 1010
//    -> err_out pulses once; err_cnt=1, bit_err_cnt=1; 1010 matches; remains locked.
//  4 Loss of lock:
//    locked, four consecutive corrupted beats
//    -> err_cnt=4, locked_out falls after the 4th; next nonzero word enters SYNC.
//  5 Zero rejection and reseed:
//    in HUNT send 0000, then 1001, 0000, 1001, 1100, 0110, 1011
//    -> 0000 is ignored in HUNT; the 0000 in SYNC returns to HUNT;
//       lock follows the second 1001 run.
//  6 Gaps, clear, saturation:
//    - Idle cycles between beats -> no state change.
//    - clr_in with an error on the same beat -> err_cnt=1.
//    - CNT_WIDTH=2 with 5 errors -> err_cnt holds at 3.

Source files
------------

// File: rtl/lfsr_checker_if.sv
// Stream interface between an LFSR pattern source and the checker.
// The checker sits on the slave side; the source/bench drives the master side.
interface lfsr_checker_if #(
  parameter int BIT_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) ();
  logic                 valid_in;
  logic [BIT_WIDTH-1:0] data_in;
  logic                 clr_in;
  logic                 locked_out;
  logic                 err_out;
  logic [CNT_WIDTH-1:0] err_cnt_out;
  logic [CNT_WIDTH-1:0] bit_err_cnt_out;

  modport master (
    output valid_in, data_in, clr_in,
    input  locked_out, err_out, err_cnt_out, bit_err_cnt_out
  );

  modport slave (
    input  valid_in, data_in, clr_in,
    output locked_out, err_out, err_cnt_out, bit_err_cnt_out
  );
endinterface

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the incoming stream, predicts each
// following word, and keeps saturating word/bit error counts while locked.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | waiting for a nonzero word to seed the local LFSR
// SYNC   | seeded; counting consecutive correct predictions
// LOCKED | tracking the stream; mismatches are counted as errors
module lfsr_checker #(
  parameter int BIT_WIDTH    = 4,
  parameter int SYNC_MATCHES = 3,
  parameter int LOSS_THRESH  = 4,
  parameter int CNT_WIDTH    = 16
) (
  input logic           clk,
  input logic           rstn,
  lfsr_checker_if.slave bus
);

  localparam int SW = $clog2(SYNC_MATCHES + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  localparam int PW = $clog2(BIT_WIDTH + 1);
  // Adder wide enough for either operand plus a carry, so overflow is visible.
  localparam int AW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] expected, expected_nxt;
  logic [SW-1:0]        sync_cnt, sync_cnt_nxt;
  logic [LW-1:0]        loss_cnt, loss_cnt_nxt;
  logic [CNT_WIDTH-1:0] err_cnt, err_cnt_nxt;
  logic [CNT_WIDTH-1:0] bit_err_cnt, bit_err_cnt_nxt;
  logic                 err_q, err_nxt;
  logic                 locked_q;
  logic [PW-1:0]        bit_inc;
  logic [CNT_WIDTH-1:0] err_base, bit_base;
  logic                 match, nonzero;

  function automatic logic [BIT_WIDTH-1:0] lfsr_nxt(input logic [BIT_WIDTH-1:0] s);
    return {s[1] ^ s[0], s[BIT_WIDTH-1:1]};
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [BIT_WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < BIT_WIDTH; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // Clamp to all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [PW-1:0] inc);
    logic [AW-1:0] sum;
    sum = AW'(base) + AW'(inc);
    if (sum > AW'({CNT_WIDTH{1'b1}})) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  assign match   = (bus.data_in == expected);
  assign nonzero = |bus.data_in;

  // Next-state, prediction and error-accounting logic.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    sync_cnt_nxt = sync_cnt;
    loss_cnt_nxt = loss_cnt;
    err_nxt      = 1'b0;
    bit_inc      = '0;

    if (bus.valid_in) begin
      unique case (state)
        HUNT: begin
          // An all-zero word is the LFSR lock-up value and cannot seed.
          if (nonzero) begin
            expected_nxt = lfsr_nxt(bus.data_in);
            sync_cnt_nxt = '0;
            state_nxt    = SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            expected_nxt = lfsr_nxt(expected);
            sync_cnt_nxt = sync_cnt + SW'(1);
            if (sync_cnt == SW'(SYNC_MATCHES - 1)) begin
              state_nxt    = LOCKED;
              loss_cnt_nxt = '0;
            end
          end else if (nonzero) begin
            expected_nxt = lfsr_nxt(bus.data_in);
            sync_cnt_nxt = '0;
          end else begin
            sync_cnt_nxt = '0;
            state_nxt    = HUNT;
          end
        end
        LOCKED: begin
          // Free-run from our own prediction; corrupted input never reseeds.
          expected_nxt = lfsr_nxt(expected);
          if (match) begin
            loss_cnt_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            bit_inc = popcount(bus.data_in ^ expected);
            if (loss_cnt == LW'(LOSS_THRESH - 1)) begin
              state_nxt    = HUNT;
              sync_cnt_nxt = '0;
              loss_cnt_nxt = '0;
            end else begin
              loss_cnt_nxt = loss_cnt + LW'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // Clear acts as a zero base, so a same-cycle error leaves just its increment.
    err_base        = bus.clr_in ? '0 : err_cnt;
    bit_base        = bus.clr_in ? '0 : bit_err_cnt;
    err_cnt_nxt     = err_nxt ? sat_add(err_base, PW'(1)) : err_base;
    bit_err_cnt_nxt = err_nxt ? sat_add(bit_base, bit_inc) : bit_base;
  end

  // State and registered outputs; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= HUNT;
      expected    <= '0;
      sync_cnt    <= '0;
      loss_cnt    <= '0;
      err_cnt     <= '0;
      bit_err_cnt <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      expected    <= expected_nxt;
      sync_cnt    <= sync_cnt_nxt;
      loss_cnt    <= loss_cnt_nxt;
      err_cnt     <= err_cnt_nxt;
      bit_err_cnt <= bit_err_cnt_nxt;
      err_q       <= err_nxt;
      locked_q    <= (state_nxt == LOCKED);
    end
  end

  assign bus.locked_out      = locked_q;
  assign bus.err_out         = err_q;
  assign bus.err_cnt_out     = err_cnt;
  assign bus.bit_err_cnt_out = bit_err_cnt;

endmodule
